bitserial_add_ctrl: RTL and testbench
=====================================

Name: bitserial_add_ctrl

Overview:
Sequencer for the one-bit full-adder cell. It accepts a parallel operand pair over a valid/ready handshake and feeds the cell LSB-first, one bit per clock. A registered carry loops the cell's carry-out back to its carry-in, and the sum bits are collected into a parallel result that is returned over a second valid/ready handshake. It sits between the parallel register/control side and the bit-serial datapath, and supports add and subtract.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..64)
CNT_W, $clog2(WIDTH), bit-counter width (derived, not overridden)

Ports:
i_clk  input  1  clock, all state rising-edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  operand pair valid
o_ready  output  1  controller can accept operands
i_data_a  input  WIDTH  operand A
i_data_b  input  WIDTH  operand B
i_sub  input  1  1 = A-B, 0 = A+B; sampled at accept
o_valid  output  1  result valid
i_ready  input  1  consumer accepts result
o_data_sum  output  WIDTH  result
o_data_carry  output  1  final carry-out (for subtract: 1 = no borrow)
o_overflow  output  1  signed overflow, i.e. carry into MSB XOR carry out of MSB
o_busy  output  1  high in RUN

Behaviour:
- Reset (async assert, sync-released by upstream): state=IDLE; o_valid, o_data_sum, o_data_carry, o_overflow, o_busy all 0; counter, shift registers and carry register all 0. Assertion mid-RUN or mid-DONE aborts the operation with no partial result.
- FSM states:
  - IDLE: o_ready=1. On i_valid&o_ready, go to RUN.
  - RUN: o_busy=1, o_ready=0. Runs for exactly WIDTH cycles, then goes to DONE.
  - DONE: o_valid=1. On i_ready, go to IDLE, or straight to RUN if a new operand is accepted in the same cycle.
- o_ready = (state==IDLE) | (state==DONE & i_ready). This allows back-to-back operations with no bubble.
- On accept:
  - Load A into shift register sa.
  - Load B into sb, or ~B when i_sub.
  - Carry register c = i_sub.
  - Counter = 0.
  - Latch the sub flag (informational only).
- RUN cycle k (k=0..WIDTH-1):
  - Cell inputs are a=sa[0], b=sb[0], c=c.
  - sa and sb shift right by one.
  - Cell sum shifts into result register bit WIDTH-1; after WIDTH shifts, bit k has landed at position k.
  - c <= cell carry.
  - At k==WIDTH-1, capture the incoming carry c (carry into MSB) for the overflow calculation.
  - Counter increments; at WIDTH-1 the FSM moves to DONE.
- Latency: accept at edge T, o_valid high after edge T+WIDTH. That is WIDTH cycles from accept to valid, independent of operand values.
- Result registers (o_data_sum, o_data_carry, o_overflow) update only on the RUN→DONE transition. They hold stable while o_valid & !i_ready (backpressure), and retain their last value in IDLE.
- i_valid while o_ready=0 is ignored; operands must be held by the producer until accepted. Operand changes after accept have no effect.
- i_ready is ignored while o_valid=0.
- Arithmetic is modulo 2^WIDTH. Carry and overflow follow standard two's-complement rules.

Decomposition:
- Shared package bitserial_pkg holds:
  - the state enum (IDLE, RUN, DONE), typedef state_t;
  - default width constant BS_WIDTH=8;
  - the op encoding constants OP_ADD=0, OP_SUB=1.
- One sub-module instance: the existing one-bit full-adder cell (alu). The controller holds no combinational add logic of its own.
- The shift/counter datapath and FSM live in this module.

Test Plan:
- WIDTH=8, add: A=0x5A, B=0x3C, i_sub=0 -> after 8 cycles o_valid=1, o_data_sum=0x96, o_data_carry=0, o_overflow=1.
- Add wrap: A=0xFF, B=0x01 -> sum=0x00, carry=1, overflow=0. Also check o_valid rises exactly 8 cycles after the accept edge.
- Subtract:
  - 0x10-0x20 -> sum=0xF0, carry=0, overflow=0.
  - 0x80-0x01 -> sum=0x7F, carry=1, overflow=1.
- Backpressure and back-to-back:
  - Hold i_ready=0 for 5 cycles in DONE -> outputs stable and o_ready=0.
  - Then assert i_ready together with i_valid (A=0x01, B=0x02) -> accepted in the same cycle; next o_valid has sum=0x03 with no idle bubble.
- Reset and protocol:
  - Assert i_rst_n=0 at RUN cycle 3 -> all outputs immediately 0 and state IDLE; after release, a new add 0x0F+0x01 gives 0x10.
  - i_valid pulses during RUN are not accepted.

Source files
------------

// File: rtl/bitserial_pkg.sv
// bitserial_pkg
// Shared definitions for the bit-serial add/subtract controller.
//   state_t  : controller FSM states (IDLE, RUN, DONE)
//   BS_WIDTH : default operand/result width
//   OP_ADD / OP_SUB : encoding of the i_sub operation select
package bitserial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BS_WIDTH = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/bitserial_add_ctrl_alu.sv
// alu
// One-bit full-adder cell used by the bit-serial controller.
// Ports:
//   a, b   : operand bits
//   c_in   : carry in
//   sum    : sum bit
//   c_out  : carry out
module alu (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/bitserial_add_ctrl.sv
// bitserial_add_ctrl
// Sequencer that feeds a one-bit full-adder cell LSB-first, one bit per clock,
// and returns the collected parallel result. Supports A+B and A-B.
// Ports:
//   i_clk, i_rst_n          : clock (rising edge) and async active-low reset
//   i_valid / o_ready       : operand handshake (i_data_a, i_data_b, i_sub)
//   o_valid / i_ready       : result handshake (o_data_sum, o_data_carry, o_overflow)
//   o_busy                  : high while bits are being processed
module bitserial_add_ctrl
    import bitserial_pkg::*;
#(
    parameter  int WIDTH = BS_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data_a,
    input  logic [WIDTH-1:0] i_data_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data_sum,
    output logic             o_data_carry,
    output logic             o_overflow,
    output logic             o_busy
);

    state_t             state;
    logic [WIDTH-1:0]   sa;
    logic [WIDTH-1:0]   sb;
    logic [WIDTH-1:0]   res;
    logic [CNT_W-1:0]   cnt;
    logic               c;
    logic               cell_sum;
    logic               cell_carry;
    logic               accept;
    logic               last_bit;
    logic [WIDTH-1:0]   next_res;

    alu u_alu (
        .a     (sa[0]),
        .b     (sb[0]),
        .c_in  (c),
        .sum   (cell_sum),
        .c_out (cell_carry)
    );

    // Ready is combinational on i_ready so a finished result can be handed
    // off and a new operand pair taken in the same cycle.
    assign o_ready  = (state == IDLE) || ((state == DONE) && i_ready);
    assign accept   = i_valid && o_ready;
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign next_res = {cell_sum, res[WIDTH-1:1]};

    // Subtraction is A + ~B + 1: B is inverted on load and the carry register
    // is preset to 1, so the cell itself never needs to know the operation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            sa           <= '0;
            sb           <= '0;
            res          <= '0;
            cnt          <= '0;
            c            <= 1'b0;
            o_valid      <= 1'b0;
            o_busy       <= 1'b0;
            o_data_sum   <= '0;
            o_data_carry <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= next_res;
                    c   <= cell_carry;
                    cnt <= cnt + 1'b1;
                    if (last_bit) begin
                        // At the MSB, c still holds the carry into the MSB.
                        o_data_sum   <= next_res;
                        o_data_carry <= cell_carry;
                        o_overflow   <= c ^ cell_carry;
                        o_valid      <= 1'b1;
                        o_busy       <= 1'b0;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // A new operand pair overrides the IDLE/DONE transitions above.
            if (accept) begin
                sa      <= i_data_a;
                sb      <= (i_sub == OP_SUB) ? ~i_data_b : i_data_b;
                c       <= (i_sub == OP_SUB);
                cnt     <= '0;
                o_valid <= 1'b0;
                o_busy  <= 1'b1;
                state   <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_bitserial_add_ctrl.sv
// tb_bitserial_add_ctrl
// Self-checking bench for bitserial_add_ctrl (WIDTH=8): directed cases,
// backpressure, back-to-back handoff, mid-run reset, ignored i_valid during
// RUN, and randomized add/subtract against an arithmetic reference model.
module tb_bitserial_add_ctrl;

    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_data_a;
    logic [W-1:0] i_data_b;
    logic         i_sub;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_data_sum;
    logic         o_data_carry;
    logic         o_overflow;
    logic         o_busy;

    int check_count = 0;
    int pass_count  = 0;

    bitserial_add_ctrl #(.WIDTH(W)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data_a     (i_data_a),
        .i_data_b     (i_data_b),
        .i_sub        (i_sub),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data_sum   (o_data_sum),
        .o_data_carry (o_data_carry),
        .o_overflow   (o_overflow),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Reference: plain modular and signed integer arithmetic.
    task automatic refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                            output logic [W-1:0] sum, output logic carry, output logic ovf);
        logic [W:0] u;
        int r;
        if (sub) begin
            sum   = a - b;
            carry = (a >= b);
            r     = int'($signed(a)) - int'($signed(b));
        end else begin
            u     = {1'b0, a} + {1'b0, b};
            sum   = u[W-1:0];
            carry = u[W];
            r     = int'($signed(a)) + int'($signed(b));
        end
        ovf = (r > 127) || (r < -128);
    endtask

    // Presents an operand pair and returns just after the accepting edge.
    task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        int cyc = 0;
        i_valid  = 1'b1;
        i_data_a = a;
        i_data_b = b;
        i_sub    = sub;
        #1;
        while (!o_ready && cyc < 50) begin
            @(posedge i_clk); #1;
            cyc++;
        end
        if (!o_ready) checkOutput("accept_timeout", o_ready, 1'b1);
        @(posedge i_clk); #1;
        i_valid  = 1'b0;
        i_data_a = W'($urandom);
        i_data_b = W'($urandom);
        i_sub    = 1'($urandom);
    endtask

    // Counts edges until o_valid, bounded.
    task automatic waitResult(output int cyc);
        cyc = 0;
        while (!o_valid && cyc < 4 * W) begin
            @(posedge i_clk); #1;
            cyc++;
        end
        if (!o_valid) checkOutput("valid_timeout", o_valid, 1'b1);
    endtask

    task automatic checkResult(input string tag, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic sub);
        logic [W-1:0] es;
        logic ec, eo;
        refModel(a, b, sub, es, ec, eo);
        checkOutput({tag, "_sum"},   o_data_sum,   es);
        checkOutput({tag, "_carry"}, o_data_carry, ec);
        checkOutput({tag, "_ovf"},   o_overflow,   eo);
    endtask

    task automatic consume();
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic sub);
        int cyc;
        startOp(a, b, sub);
        waitResult(cyc);
        checkOutput({tag, "_latency"}, cyc, W);
        checkResult(tag, a, b, sub);
        consume();
    endtask

    initial begin
        int cyc;
        logic [W-1:0] ra, rb;
        logic rs;

        i_rst_n  = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_data_a = '0;
        i_data_b = '0;
        i_sub    = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("rst_valid", o_valid, 1'b0);
        checkOutput("rst_busy",  o_busy,  1'b0);
        checkOutput("rst_sum",   o_data_sum, '0);
        checkOutput("rst_carry", o_data_carry, 1'b0);
        checkOutput("rst_ovf",   o_overflow, 1'b0);
        checkOutput("rst_ready", o_ready, 1'b1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        applyStimulus("add_wrap", 8'hFF, 8'h01, 1'b0);
        applyStimulus("sub_neg",  8'h10, 8'h20, 1'b1);
        applyStimulus("sub_ovf",  8'h80, 8'h01, 1'b1);

        // Backpressure on 0x5A+0x3C, then a same-cycle handoff into 0x01+0x02.
        startOp(8'h5A, 8'h3C, 1'b0);
        waitResult(cyc);
        checkOutput("bp_latency", cyc, W);
        checkResult("bp_add", 8'h5A, 8'h3C, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk); #1;
            checkOutput("bp_valid", o_valid, 1'b1);
            checkOutput("bp_ready", o_ready, 1'b0);
            checkResult("bp_hold", 8'h5A, 8'h3C, 1'b0);
        end
        i_ready  = 1'b1;
        i_valid  = 1'b1;
        i_data_a = 8'h01;
        i_data_b = 8'h02;
        i_sub    = 1'b0;
        #1;
        checkOutput("b2b_ready", o_ready, 1'b1);
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        i_valid = 1'b0;
        checkOutput("b2b_valid_low", o_valid, 1'b0);
        checkOutput("b2b_busy", o_busy, 1'b1);
        waitResult(cyc);
        checkOutput("b2b_latency", cyc, W);
        checkResult("b2b", 8'h01, 8'h02, 1'b0);
        consume();

        // i_valid during RUN must not be taken.
        startOp(8'h21, 8'h13, 1'b1);
        for (int i = 0; i < 4; i++) begin
            i_valid  = 1'b1;
            i_data_a = W'($urandom);
            i_data_b = W'($urandom);
            @(posedge i_clk); #1;
            checkOutput("run_ready", o_ready, 1'b0);
            checkOutput("run_busy",  o_busy,  1'b1);
        end
        i_valid = 1'b0;
        waitResult(cyc);
        checkOutput("run_latency", cyc, W - 4);
        checkResult("run_ignore", 8'h21, 8'h13, 1'b1);
        consume();

        // Reset during RUN cycle 3 aborts everything.
        startOp(8'h33, 8'h44, 1'b0);
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", o_valid, 1'b0);
        checkOutput("arst_busy",  o_busy,  1'b0);
        checkOutput("arst_sum",   o_data_sum, '0);
        checkOutput("arst_carry", o_data_carry, 1'b0);
        checkOutput("arst_ovf",   o_overflow, 1'b0);
        checkOutput("arst_ready", o_ready, 1'b1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        applyStimulus("post_rst", 8'h0F, 8'h01, 1'b0);

        for (int n = 0; n < 20; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            applyStimulus($sformatf("rand%0d", n), ra, rb, rs);
            checkOutput("idle_hold_valid", o_valid, 1'b0);
            checkResult($sformatf("rand%0d_hold", n), ra, rb, rs);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
